alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl.sv | 119 +++++++++++
 tb/tb_alu_share_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared combinational ALU and buffers one response per requester
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ImmBus
`define ImmBus 31:0
`endif
`ifndef ALU_Result_Bus
`define ALU_Result_Bus 31:0
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'h0
`define ALU_OP_SUB  4'h1
`define ALU_OP_AND  4'h2
`define ALU_OP_OR   4'h3
`define ALU_OP_SLL  4'h4
`define ALU_OP_SRL  4'h5
`define ALU_OP_SLTU 4'h6
`define ALU_OP_BEQ  4'h7
`define ALU_OP_JAL  4'h8
`endif
module alu_share_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r0_valid,
  output logic                   r0_ready,
  input  logic [3:0]             r0_op,
  input  logic                   r0_alu_src,
  input  logic [`RegBus]         r0_data1,
  input  logic [`RegBus]         r0_data2,
  input  logic [`ImmBus]         r0_imm,
  output logic                   r0_rsp_valid,
  input  logic                   r0_rsp_ready,
  output logic [`ALU_Result_Bus] r0_rsp_result,
  output logic                   r0_rsp_zero,
  output logic                   r0_rsp_err,
  input  logic                   r1_valid,
  output logic                   r1_ready,
  input  logic [3:0]             r1_op,
  input  logic                   r1_alu_src,
  input  logic [`RegBus]         r1_data1,
  input  logic [`RegBus]         r1_data2,
  input  logic [`ImmBus]         r1_imm,
  output logic                   r1_rsp_valid,
  input  logic                   r1_rsp_ready,
  output logic [`ALU_Result_Bus] r1_rsp_result,
  output logic                   r1_rsp_zero,
  output logic                   r1_rsp_err,
  output logic                   alu_src,
  output logic [3:0]             alu_ctrl,
  output logic [`RegBus]         alu_data1,
  output logic [`RegBus]         alu_data2,
  output logic [`ImmBus]         alu_imm,
  input  logic [`ALU_Result_Bus] alu_result,
  input  logic                   alu_zero
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state;
  logic owner, last, elig0, elig1, g0, g1, legal, br;
  logic [`ALU_Result_Bus] res;
  // last = requester granted most recently; reset value 1 lets r0 win first
  always_comb begin
    elig0 = (!r0_rsp_valid || r0_rsp_ready) && !(state == EXEC && !owner);
    elig1 = (!r1_rsp_valid || r1_rsp_ready) && !(state == EXEC && owner);
    r0_ready = !rst && elig0 && !(RR_EN && r1_valid && elig1 && !last);
    r1_ready = !rst && elig1 && !(r0_valid && elig0 && (!RR_EN || last));
    g0 = r0_valid && r0_ready;
    g1 = r1_valid && r1_ready;
    legal = alu_ctrl inside {`ALU_OP_ADD, `ALU_OP_SUB, `ALU_OP_AND, `ALU_OP_OR,
                             `ALU_OP_SLL, `ALU_OP_SRL, `ALU_OP_SLTU};
    br = alu_ctrl inside {`ALU_OP_BEQ, `ALU_OP_JAL};
    res = legal ? alu_result : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      alu_src <= 1'b0;
      alu_ctrl <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_imm <= '0;
      r0_rsp_valid <= 1'b0;
      r0_rsp_result <= '0;
      r0_rsp_zero <= 1'b0;
      r0_rsp_err <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_result <= '0;
      r1_rsp_zero <= 1'b0;
      r1_rsp_err <= 1'b0;
    end else begin
      state <= (g0 || g1) ? EXEC : IDLE;
      if (g0 || g1) begin
        owner <= g1;
        last <= g1;
        alu_src <= g1 ? r1_alu_src : r0_alu_src;
        alu_ctrl <= g1 ? r1_op : r0_op;
        alu_data1 <= g1 ? r1_data1 : r0_data1;
        alu_data2 <= g1 ? r1_data2 : r0_data2;
        alu_imm <= g1 ? r1_imm : r0_imm;
      end
      if (state == EXEC && !owner) begin
        r0_rsp_valid <= 1'b1;
        r0_rsp_result <= res;
        r0_rsp_zero <= br && alu_zero;
        r0_rsp_err <= !legal && !br;
      end else if (r0_rsp_ready) r0_rsp_valid <= 1'b0;
      if (state == EXEC && owner) begin
        r1_rsp_valid <= 1'b1;
        r1_rsp_result <= res;
        r1_rsp_zero <= br && alu_zero;
        r1_rsp_err <= !legal && !br;
      end else if (r1_rsp_ready) r1_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of alu_share_ctrl, instance 0 round-robin, instance 1 fixed priority
module tb_alu_share_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic r0_valid = 0, r0_alu_src = 0, r0_rsp_ready = 0;
  logic r1_valid = 0, r1_alu_src = 0, r1_rsp_ready = 0;
  logic [3:0] r0_op = 0, r1_op = 0;
  logic [31:0] r0_data1 = 0, r0_data2 = 0, r0_imm = 0;
  logic [31:0] r1_data1 = 0, r1_data2 = 0, r1_imm = 0;
  logic r0_ready[2], r1_ready[2], r0_rsp_valid[2], r1_rsp_valid[2];
  logic r0_rsp_zero[2], r1_rsp_zero[2], r0_rsp_err[2], r1_rsp_err[2];
  logic [31:0] r0_rsp_result[2], r1_rsp_result[2];
  logic alu_src[2], alu_zero[2];
  logic [3:0] alu_ctrl[2];
  logic [31:0] alu_data1[2], alu_data2[2], alu_imm[2], alu_result[2];
  int passed = 0, failed = 0, total = 0;
  always #5 clk = ~clk;
  function automatic logic [32:0] alu_f(input logic [3:0] c, input logic s, input logic [31:0] a, d, i);
    logic [31:0] b, r;
    b = s ? i : d;
    case (c)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a << b[4:0];
      4'h5: r = a >> b[4:0];
      4'h6: r = {31'b0, a < b};
      4'h7: r = a - b;
      4'h8: r = a + b;
      default: r = 32'hDEAD_BEEF;
    endcase
    return {r == 32'h0, r};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_ctrl #(.RR_EN(g == 0)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready[g]), .r0_op(r0_op), .r0_alu_src(r0_alu_src),
      .r0_data1(r0_data1), .r0_data2(r0_data2), .r0_imm(r0_imm),
      .r0_rsp_valid(r0_rsp_valid[g]), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_result(r0_rsp_result[g]),
      .r0_rsp_zero(r0_rsp_zero[g]), .r0_rsp_err(r0_rsp_err[g]),
      .r1_valid(r1_valid), .r1_ready(r1_ready[g]), .r1_op(r1_op), .r1_alu_src(r1_alu_src),
      .r1_data1(r1_data1), .r1_data2(r1_data2), .r1_imm(r1_imm),
      .r1_rsp_valid(r1_rsp_valid[g]), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_result(r1_rsp_result[g]),
      .r1_rsp_zero(r1_rsp_zero[g]), .r1_rsp_err(r1_rsp_err[g]),
      .alu_src(alu_src[g]), .alu_ctrl(alu_ctrl[g]), .alu_data1(alu_data1[g]), .alu_data2(alu_data2[g]),
      .alu_imm(alu_imm[g]), .alu_result(alu_result[g]), .alu_zero(alu_zero[g])
    );
    assign {alu_zero[g], alu_result[g]} = alu_f(alu_ctrl[g], alu_src[g], alu_data1[g], alu_data2[g], alu_imm[g]);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    r0_valid = 1;
    tick;
    tick;
    chk("rst_r0_ready", r0_ready[0], 0);
    chk("rst_r1_ready", r1_ready[0], 0);
    chk("rst_r0_rsp_valid", r0_rsp_valid[0], 0);
    chk("rst_r0_result", r0_rsp_result[0], 0);
    chk("rst_alu_data1", alu_data1[0], 0);
    r0_valid = 0;
    rst = 0;
    #2 chk("idle_r0_ready", r0_ready[0], 1);
    r0_valid = 1; r0_op = 4'h0; r0_data1 = 5; r0_data2 = 7; r0_alu_src = 0; r0_imm = 100;
    tick;
    r0_valid = 0;
    chk("add_alu_ctrl", alu_ctrl[0], 4'h0);
    chk("add_alu_data1", alu_data1[0], 5);
    chk("add_alu_data2", alu_data2[0], 7);
    chk("add_alu_imm", alu_imm[0], 100);
    chk("add_t1_rsp_valid", r0_rsp_valid[0], 0);
    chk("add_t1_r0_ready", r0_ready[0], 0);
    tick;
    chk("add_rsp_valid", r0_rsp_valid[0], 1);
    chk("add_result", r0_rsp_result[0], 12);
    chk("add_zero", r0_rsp_zero[0], 0);
    chk("add_err", r0_rsp_err[0], 0);
    r0_valid = 1; r0_op = 4'h1; r0_data1 = 9; r0_data2 = 2;
    r1_valid = 1; r1_op = 4'h3; r1_alu_src = 1; r1_data1 = 32'hF0; r1_data2 = 1; r1_imm = 32'h0F;
    #2 chk("bp_r0_ready", r0_ready[0], 0);
    chk("bp_r1_ready", r1_ready[0], 1);
    tick;
    r1_valid = 0;
    chk("bp_r0_hold", r0_rsp_result[0], 12);
    chk("bp_r0_hold_valid", r0_rsp_valid[0], 1);
    chk("bp_alu_ctrl_or", alu_ctrl[0], 4'h3);
    chk("bp_alu_src", alu_src[0], 1);
    chk("bp_r0_ready_still", r0_ready[0], 0);
    r0_rsp_ready = 1;
    #2 chk("bp_release_r0_ready", r0_ready[0], 1);
    tick;
    r0_valid = 0;
    chk("or_r1_rsp_valid", r1_rsp_valid[0], 1);
    chk("or_r1_result", r1_rsp_result[0], 32'hFF);
    chk("pop_r0_rsp_valid", r0_rsp_valid[0], 0);
    chk("sub_alu_ctrl", alu_ctrl[0], 4'h1);
    tick;
    chk("sub_rsp_valid", r0_rsp_valid[0], 1);
    chk("sub_result", r0_rsp_result[0], 7);
    r1_rsp_ready = 1;
    tick;
    chk("drain_r0", r0_rsp_valid[0], 0);
    chk("drain_r1", r1_rsp_valid[0], 0);
    r0_valid = 1; r0_op = 4'h7; r0_alu_src = 0; r0_data1 = 3; r0_data2 = 3;
    tick;
    r0_valid = 0;
    tick;
    chk("beq_eq_zero", r0_rsp_zero[0], 1);
    chk("beq_eq_result", r0_rsp_result[0], 0);
    chk("beq_eq_err", r0_rsp_err[0], 0);
    r0_valid = 1; r0_data2 = 4;
    tick;
    r0_valid = 0;
    tick;
    chk("beq_ne_valid", r0_rsp_valid[0], 1);
    chk("beq_ne_zero", r0_rsp_zero[0], 0);
    r0_valid = 1; r0_op = 4'hF; r0_data1 = 1; r0_data2 = 2;
    tick;
    r0_valid = 0;
    tick;
    chk("ill_err", r0_rsp_err[0], 1);
    chk("ill_result", r0_rsp_result[0], 0);
    chk("ill_zero", r0_rsp_zero[0], 0);
    r0_valid = 1; r0_op = 4'h0; r0_data1 = 5; r0_data2 = 7;
    tick;
    r0_valid = 0;
    rst = 1;
    tick;
    chk("midrst_rsp_valid", r0_rsp_valid[0], 0);
    chk("midrst_alu_data1", alu_data1[0], 0);
    chk("midrst_alu_ctrl", alu_ctrl[0], 0);
    chk("midrst_result", r0_rsp_result[0], 0);
    rst = 0;
    tick;
    chk("midrst_no_late_rsp", r0_rsp_valid[0], 0);
    #2 chk("midrst_idle_r0_ready", r0_ready[0], 1);
    chk("midrst_idle_r1_ready", r1_ready[0], 1);
    tick;
    r0_valid = 1; r0_op = 4'h0; r0_data1 = 1; r0_data2 = 1;
    r1_valid = 1; r1_op = 4'h0; r1_alu_src = 0; r1_data1 = 2; r1_data2 = 2;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("rr_r0_ready_%0d", k), r0_ready[0], k % 2 == 0);
      chk($sformatf("rr_r1_ready_%0d", k), r1_ready[0], k % 2 == 1);
      chk($sformatf("fp_r0_ready_%0d", k), r0_ready[1], k % 2 == 0);
      chk($sformatf("fp_r1_ready_%0d", k), r1_ready[1], k % 2 == 1);
      chk($sformatf("rr_r0_rsp_%0d", k), r0_rsp_valid[0], k >= 2 && k % 2 == 0);
      chk($sformatf("rr_r1_rsp_%0d", k), r1_rsp_valid[0], k >= 3 && k % 2 == 1);
      if (k > 0) chk($sformatf("rr_alu_data1_%0d", k), alu_data1[0], (k % 2 == 1) ? 1 : 2);
      if (k == 3) chk("rr_r1_result", r1_rsp_result[0], 4);
      tick;
    end
    r0_valid = 0; r1_valid = 0;
    tick;
    tick;
    tick;
    r0_valid = 1;
    tick;
    r0_valid = 0;
    tick;
    tick;
    tick;
    r0_valid = 1; r1_valid = 1;
    #2 chk("rr_after_r0_r0_ready", r0_ready[0], 0);
    chk("rr_after_r0_r1_ready", r1_ready[0], 1);
    chk("fp_after_r0_r0_ready", r0_ready[1], 1);
    chk("fp_after_r0_r1_ready", r1_ready[1], 0);
    tick;
    r0_valid = 0; r1_valid = 0;
    chk("rr_grant_r1_data", alu_data1[0], 2);
    chk("fp_grant_r0_data", alu_data1[1], 1);
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
